// File: rtl/dmem_access_unit_pkg.sv
// Shared types and constants for the data-memory access stage.
// The ext_type bit indices are shared with the load/store decode unit.
package dmem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int EXT_W   = 9;
  localparam int EXT_LB  = 8;
  localparam int EXT_LBU = 7;
  localparam int EXT_LH  = 6;
  localparam int EXT_LHU = 5;
  localparam int EXT_LW  = 4;
  localparam int EXT_LWL = 3;
  localparam int EXT_LWR = 2;
  localparam int EXT_SWL = 1;
  localparam int EXT_SWR = 0;

endpackage

// File: rtl/dmem_access_unit_if.sv
// Execute-side op handshake, data-bus request/response and writeback signals.
interface dmem_access_unit_if #(
  parameter int ADDR_W = 32
);
  // ex_valid/ex_ready and req_valid/req_ready transfer when both are high on a
  // rising clock edge; a valid stays asserted with stable payload until then.
  // resp_valid is a single beat with no backpressure.
  logic              ex_valid;
  logic              ex_ready;
  logic              ex_is_load;
  logic              ex_is_store;
  logic [ADDR_W-1:0] ex_addr;
  logic [31:0]       ex_wdata;
  logic [3:0]        ex_wstrb;
  logic [8:0]        ex_ext_type;
  logic [31:0]       ex_rt_old;
  logic              ex_addr_err;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_wstrb;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              wb_valid;
  logic              wb_we;
  logic [31:0]       wb_data;

  modport master (
    input  ex_valid, ex_is_load, ex_is_store, ex_addr, ex_wdata, ex_wstrb,
           ex_ext_type, ex_rt_old, ex_addr_err, flush, req_ready, resp_valid,
           resp_rdata,
    output ex_ready, req_valid, req_wr, req_addr, req_wstrb, req_wdata,
           wb_valid, wb_we, wb_data
  );

  modport slave (
    output ex_valid, ex_is_load, ex_is_store, ex_addr, ex_wdata, ex_wstrb,
           ex_ext_type, ex_rt_old, ex_addr_err, flush, req_ready, resp_valid,
           resp_rdata,
    input  ex_ready, req_valid, req_wr, req_addr, req_wstrb, req_wdata,
           wb_valid, wb_we, wb_data
  );

endinterface

// File: rtl/dmem_access_unit_load_data_align.sv
// Combinational load extension and lwl/lwr merge of returned read data.
module dmem_access_unit_load_data_align
  import dmem_access_unit_pkg::*;
(
  input  logic [31:0]      rdata,
  input  logic [31:0]      rt_old,
  input  logic [1:0]       offset,
  input  logic [EXT_W-1:0] ext_type,
  output logic [31:0]      result
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] lwl_val;
  logic [31:0] lwr_val;
  logic        unused_store_bits;

  assign unused_store_bits = ^{ext_type[EXT_SWL], ext_type[EXT_SWR]};

  always_comb begin
    lane_byte = rdata[7:0];
    lwl_val   = rdata;
    lwr_val   = rdata;
    case (offset)
      2'd0: begin
        lane_byte = rdata[7:0];
        lwl_val   = {rdata[7:0], rt_old[23:0]};
        lwr_val   = rdata;
      end
      2'd1: begin
        lane_byte = rdata[15:8];
        lwl_val   = {rdata[15:0], rt_old[15:0]};
        lwr_val   = {rt_old[31:24], rdata[31:8]};
      end
      2'd2: begin
        lane_byte = rdata[23:16];
        lwl_val   = {rdata[23:0], rt_old[7:0]};
        lwr_val   = {rt_old[31:16], rdata[31:16]};
      end
      default: begin
        lane_byte = rdata[31:24];
        lwl_val   = rdata;
        lwr_val   = {rt_old[31:8], rdata[31:24]};
      end
    endcase
  end

  assign lane_half = offset[1] ? rdata[31:16] : rdata[15:0];

  // Unrecognised or lw encodings return the full word.
  always_comb begin
    result = rdata;
    if (ext_type[EXT_LB])       result = {{24{lane_byte[7]}}, lane_byte};
    else if (ext_type[EXT_LBU]) result = {24'h0, lane_byte};
    else if (ext_type[EXT_LH])  result = {{16{lane_half[15]}}, lane_half};
    else if (ext_type[EXT_LHU]) result = {16'h0, lane_half};
    else if (ext_type[EXT_LWL]) result = lwl_val;
    else if (ext_type[EXT_LWR]) result = lwr_val;
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory stage: issues one data-bus transaction per decoded op, stalls while
// it is outstanding and presents a registered writeback result.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  dmem_access_unit_if.master  bus,
  output state_t              state_dbg
);

  state_t           state;
  logic [EXT_W-1:0] ext_q;
  logic [31:0]      rt_q;
  logic [1:0]       off_q;
  logic [31:0]      ld_result;

  dmem_access_unit_load_data_align u_align (
    .rdata    (bus.resp_rdata),
    .rt_old   (rt_q),
    .offset   (off_q),
    .ext_type (ext_q),
    .result   (ld_result)
  );

  assign bus.ex_ready = (state == ST_IDLE);
  assign state_dbg    = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      ext_q         <= '0;
      rt_q          <= '0;
      off_q         <= '0;
      bus.req_valid <= 1'b0;
      bus.req_wr    <= 1'b0;
      bus.req_addr  <= '0;
      bus.req_wstrb <= '0;
      bus.req_wdata <= '0;
      bus.wb_valid  <= 1'b0;
      bus.wb_we     <= 1'b0;
      bus.wb_data   <= '0;
    end else begin
      bus.wb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.ex_valid && !bus.flush) begin
            ext_q <= bus.ex_ext_type;
            rt_q  <= bus.ex_rt_old;
            off_q <= bus.ex_addr[1:0];
            // Misaligned or non-memory ops retire without touching the bus.
            if (bus.ex_addr_err || !(bus.ex_is_load || bus.ex_is_store)) begin
              bus.wb_valid <= 1'b1;
              bus.wb_we    <= 1'b0;
            end else begin
              bus.req_valid <= 1'b1;
              bus.req_wr    <= !bus.ex_is_load;
              bus.req_addr  <= {bus.ex_addr[ADDR_W-1:2], 2'b00};
              bus.req_wstrb <= bus.ex_is_load ? 4'h0 : bus.ex_wstrb;
              bus.req_wdata <= bus.ex_is_load ? 32'h0 : bus.ex_wdata;
              state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // A handshake wins over a coincident flush: the request is already out.
          if (bus.req_ready) begin
            bus.req_valid <= 1'b0;
            if (bus.req_wr) begin
              state <= ST_IDLE;
              if (!bus.flush) begin
                bus.wb_valid <= 1'b1;
                bus.wb_we    <= 1'b0;
              end
            end else begin
              state <= bus.flush ? ST_DRAIN : ST_WAIT;
            end
          end else if (bus.flush) begin
            bus.req_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (bus.flush) begin
            state <= bus.resp_valid ? ST_IDLE : ST_DRAIN;
          end else if (bus.resp_valid) begin
            bus.wb_valid <= 1'b1;
            bus.wb_we    <= 1'b1;
            bus.wb_data  <= ld_result;
            state        <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (bus.resp_valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed and randomized bench for dmem_access_unit with a byte-level load model.
module tb_dmem_access_unit;
  import dmem_access_unit_pkg::*;

  logic   clk = 1'b0;
  logic   resetn = 1'b0;
  state_t state_dbg;
  int     n_cmp = 0;
  int     n_mis = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_wb;

  always #5 clk = ~clk;

  dmem_access_unit_if #(.ADDR_W(32)) bus ();

  dmem_access_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  // kind: 0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5 lwl, 6 lwr (memory byte k = rd[8k+7:8k])
  function automatic logic [31:0] model_load(input int kind, input logic [1:0] o,
                                             input logic [31:0] rd, input logic [31:0] rt);
    int b[4];
    int r[4];
    int res[4];
    int v;
    int oi;
    logic [31:0] out;
    oi = int'(o);
    out = rd;
    for (int k = 0; k < 4; k++) begin
      b[k] = int'(rd[8*k +: 8]);
      r[k] = int'(rt[8*k +: 8]);
      res[k] = r[k];
    end
    case (kind)
      0, 1: begin
        v = b[oi];
        if (kind == 0 && v > 127) v = v - 256;
        out = 32'(v);
      end
      2, 3: begin
        v = b[2*(oi/2)] + 256 * b[2*(oi/2)+1];
        if (kind == 2 && v > 32767) v = v - 65536;
        out = 32'(v);
      end
      5, 6: begin
        for (int k = 0; k < 4; k++) begin
          if (kind == 5) res[k] = (k >= 3 - oi) ? b[k-(3-oi)] : r[k];
          else           res[k] = (k + oi <= 3) ? b[k+oi] : r[k];
          out[8*k +: 8] = 8'(res[k]);
        end
      end
      default: out = rd;
    endcase
    return out;
  endfunction

  function automatic logic [8:0] ext_of(input int kind);
    logic [8:0] one;
    one = 9'd1;
    return one << (EXT_LB - kind);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ex_valid = 0; bus.ex_is_load = 0; bus.ex_is_store = 0; bus.ex_addr = 0;
    bus.ex_wdata = 0; bus.ex_wstrb = 0; bus.ex_ext_type = 0; bus.ex_rt_old = 0;
    bus.ex_addr_err = 0; bus.flush = 0; bus.req_ready = 0; bus.resp_valid = 0;
    bus.resp_rdata = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_valid"}, bus.req_valid, 0);
    chk({tag, "_req_wr"}, bus.req_wr, 0);
    chk({tag, "_req_addr"}, bus.req_addr, 0);
    chk({tag, "_req_wstrb"}, bus.req_wstrb, 0);
    chk({tag, "_req_wdata"}, bus.req_wdata, 0);
    chk({tag, "_wb_valid"}, bus.wb_valid, 0);
    chk({tag, "_wb_we"}, bus.wb_we, 0);
    chk({tag, "_wb_data"}, bus.wb_data, 0);
    chk({tag, "_ex_ready"}, bus.ex_ready, 1);
    chk({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after acceptance.
  task automatic offer(input logic ld, input logic st, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic [8:0] ext, input logic [31:0] rt, input logic err);
    chk("offer_ex_ready", bus.ex_ready, 1);
    bus.ex_valid = 1; bus.ex_is_load = ld; bus.ex_is_store = st; bus.ex_addr = addr;
    bus.ex_wdata = wdata; bus.ex_wstrb = wstrb; bus.ex_ext_type = ext;
    bus.ex_rt_old = rt; bus.ex_addr_err = err;
    @(negedge clk);
    bus.ex_valid = 0; bus.ex_is_load = 0; bus.ex_is_store = 0; bus.ex_addr = 0;
    bus.ex_wdata = 0; bus.ex_wstrb = 0; bus.ex_ext_type = 0; bus.ex_rt_old = 0;
    bus.ex_addr_err = 0;
  endtask

  task automatic load_op(input int kind, input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] rt, input int req_wait, input int resp_wait,
                         input logic [31:0] exp);
    exp_q.push_back(exp);
    offer(1'b1, 1'b0, addr, 32'h0, 4'h0, ext_of(kind), rt, 1'b0);
    for (int i = 0; i <= req_wait; i++) begin
      if (i > 0) @(negedge clk);
      chk("ld_req_valid", bus.req_valid, 1);
      chk("ld_req_wr", bus.req_wr, 0);
      chk("ld_req_addr", bus.req_addr, {addr[31:2], 2'b00});
      chk("ld_req_wstrb", bus.req_wstrb, 0);
      chk("ld_ex_ready_busy", bus.ex_ready, 0);
    end
    bus.req_ready = 1;
    @(negedge clk);
    bus.req_ready = 0;
    chk("ld_req_dropped", bus.req_valid, 0);
    for (int i = 0; i < resp_wait; i++) begin
      chk("ld_wait_no_wb", bus.wb_valid, 0);
      chk("ld_wait_ex_ready", bus.ex_ready, 0);
      @(negedge clk);
    end
    bus.resp_valid = 1; bus.resp_rdata = rdata;
    @(negedge clk);
    bus.resp_valid = 0; bus.resp_rdata = $urandom;
    last_wb = exp_q.pop_front();
    chk("ld_wb_valid", bus.wb_valid, 1);
    chk("ld_wb_we", bus.wb_we, 1);
    chk("ld_wb_data", bus.wb_data, last_wb);
    chk("ld_ex_ready_done", bus.ex_ready, 1);
  endtask

  task automatic store_op(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int req_wait);
    offer(1'b0, 1'b1, addr, wdata, wstrb, ext_of(4), 32'h0, 1'b0);
    for (int i = 0; i <= req_wait; i++) begin
      if (i > 0) @(negedge clk);
      chk("st_req_valid", bus.req_valid, 1);
      chk("st_req_wr", bus.req_wr, 1);
      chk("st_req_addr", bus.req_addr, {addr[31:2], 2'b00});
      chk("st_req_wstrb", bus.req_wstrb, {28'h0, wstrb});
      chk("st_req_wdata", bus.req_wdata, wdata);
      chk("st_ex_ready_busy", bus.ex_ready, 0);
    end
    bus.req_ready = 1;
    @(negedge clk);
    bus.req_ready = 0;
    chk("st_wb_valid", bus.wb_valid, 1);
    chk("st_wb_we", bus.wb_we, 0);
    chk("st_req_dropped", bus.req_valid, 0);
    chk("st_ex_ready_done", bus.ex_ready, 1);
  endtask

  initial begin
    int kind;
    logic [31:0] a, rd, rt;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    resetn = 1;
    @(negedge clk);

    // Directed loads from the worked examples
    load_op(0, 32'h1003, 32'h80FF_1234, 32'h0, 0, 0, 32'hFFFF_FF80);
    load_op(1, 32'h1003, 32'h80FF_1234, 32'h0, 1, 1, 32'h0000_0080);
    load_op(5, 32'h2001, 32'h1122_3344, 32'hAABB_CCDD, 0, 2, 32'h3344_CCDD);
    load_op(6, 32'h2001, 32'h1122_3344, 32'hAABB_CCDD, 2, 0, 32'hAA11_2233);
    load_op(5, 32'h2003, 32'h1122_3344, 32'hAABB_CCDD, 0, 0, 32'h1122_3344);
    load_op(2, 32'h0102, 32'h9876_0011, 32'h0, 0, 0, 32'hFFFF_9876);
    @(negedge clk);
    chk("wb_pulse_one_cycle", bus.wb_valid, 0);
    chk("wb_data_hold", bus.wb_data, last_wb);

    store_op(32'h3000, 32'hDEAD_BEEF, 4'hF, 3);

    // Misaligned lw retires without bus activity
    offer(1'b1, 1'b0, 32'h4002, 32'h0, 4'h0, ext_of(4), 32'h0, 1'b1);
    chk("err_req_valid", bus.req_valid, 0);
    chk("err_wb_valid", bus.wb_valid, 1);
    chk("err_wb_we", bus.wb_we, 0);
    @(negedge clk);
    chk("err_req_valid_later", bus.req_valid, 0);

    // Neither load nor store
    offer(1'b0, 1'b0, 32'h4100, 32'h0, 4'h0, 9'h0, 32'h0, 1'b0);
    chk("nop_wb_valid", bus.wb_valid, 1);
    chk("nop_wb_we", bus.wb_we, 0);
    chk("nop_req_valid", bus.req_valid, 0);

    // Flush while offering in IDLE: op is not taken
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_ext_type = ext_of(4); bus.flush = 1;
    @(negedge clk);
    idle_inputs();
    chk("idle_flush_req", bus.req_valid, 0);
    chk("idle_flush_wb", bus.wb_valid, 0);

    // Flush in WAIT, response arrives later
    offer(1'b1, 1'b0, 32'h5004, 32'h0, 4'h0, ext_of(4), 32'h0, 1'b0);
    bus.req_ready = 1; @(negedge clk); bus.req_ready = 0;
    bus.flush = 1; @(negedge clk); bus.flush = 0;
    chk("wflush_ex_ready0", bus.ex_ready, 0);
    chk("wflush_no_wb0", bus.wb_valid, 0);
    @(negedge clk);
    chk("wflush_ex_ready1", bus.ex_ready, 0);
    bus.resp_valid = 1; bus.resp_rdata = 32'h1234_5678; @(negedge clk); bus.resp_valid = 0;
    chk("wflush_ex_ready_back", bus.ex_ready, 1);
    chk("wflush_no_wb", bus.wb_valid, 0);

    // Flush in REQ before handshake
    offer(1'b1, 1'b0, 32'h5008, 32'h0, 4'h0, ext_of(4), 32'h0, 1'b0);
    bus.flush = 1; @(negedge clk); bus.flush = 0;
    chk("rflush_req_valid", bus.req_valid, 0);
    chk("rflush_ex_ready", bus.ex_ready, 1);
    chk("rflush_no_wb", bus.wb_valid, 0);

    // Flush coincident with store handshake: completes silently
    offer(1'b0, 1'b1, 32'h500C, 32'h55AA_55AA, 4'h3, ext_of(4), 32'h0, 1'b0);
    bus.flush = 1; bus.req_ready = 1; @(negedge clk); bus.flush = 0; bus.req_ready = 0;
    chk("sflush_no_wb", bus.wb_valid, 0);
    chk("sflush_ex_ready", bus.ex_ready, 1);

    // Flush coincident with load handshake: drains the response
    offer(1'b1, 1'b0, 32'h5010, 32'h0, 4'h0, ext_of(4), 32'h0, 1'b0);
    bus.flush = 1; bus.req_ready = 1; @(negedge clk); bus.flush = 0; bus.req_ready = 0;
    chk("lflush_drain_ex_ready", bus.ex_ready, 0);
    bus.resp_valid = 1; @(negedge clk); bus.resp_valid = 0;
    chk("lflush_ex_ready_back", bus.ex_ready, 1);
    chk("lflush_no_wb", bus.wb_valid, 0);

    // Flush coincident with response
    offer(1'b1, 1'b0, 32'h5014, 32'h0, 4'h0, ext_of(4), 32'h0, 1'b0);
    bus.req_ready = 1; @(negedge clk); bus.req_ready = 0;
    bus.flush = 1; bus.resp_valid = 1; @(negedge clk); bus.flush = 0; bus.resp_valid = 0;
    chk("cflush_ex_ready", bus.ex_ready, 1);
    chk("cflush_no_wb", bus.wb_valid, 0);

    // Randomized mix of loads and stores against the byte-level model
    for (int n = 0; n < 40; n++) begin
      a = $urandom; rd = $urandom; rt = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        store_op(a, rd, 4'($urandom_range(1, 15)), $urandom_range(0, 2));
      end else begin
        kind = $urandom_range(0, 6);
        load_op(kind, a, rd, rt, $urandom_range(0, 2), $urandom_range(0, 2),
                model_load(kind, a[1:0], rd, rt));
      end
    end

    // Asynchronous reset while a load waits for its response
    offer(1'b1, 1'b0, 32'h6000, 32'h0, 4'h0, ext_of(4), 32'h0, 1'b0);
    bus.req_ready = 1; @(negedge clk); bus.req_ready = 0;
    chk("pre_rst_state", 32'(state_dbg), 32'(ST_WAIT));
    #2 resetn = 0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    chk("post_rst_ex_ready", bus.ex_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory stage sitting directly downstream of the load/store decode unit.
- Takes one decoded memory op per transaction: byte enables, 9-bit extension-type vector, offset, alignment error. Runs the data-bus request/response handshake and sign/zero-extends or merges load data (lb/lbu/lh/lhu/lw/lwl/lwr).
- Presents a registered writeback result and stalls the pipeline while a transaction is outstanding.

Parameters:
- ADDR_W, 32, data-bus address width. Data path is fixed at 32 bits.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- ex_valid  in  1  memory op offered by the execute stage.
- ex_ready  out  1  unit can accept an op this cycle.
- ex_is_load  in  1  op is a load (lb/lbu/lh/lhu/lw/lwl/lwr).
- ex_is_store  in  1  op is a store (sb/sh/sw/swl/swr).
- ex_addr  in  ADDR_W  effective byte address.
- ex_wdata  in  32  store data, already lane-shifted.
- ex_wstrb  in  4  byte write enables from decode.
- ex_ext_type  in  9  one-hot {lb,lbu,lh,lhu,lw,lwl,lwr,swl,swr}.
- ex_rt_old  in  32  old rt value, used by lwl/lwr merge.
- ex_addr_err  in  1  load or store alignment error from decode.
- flush  in  1  exception/ERET flush; kills the current op.
- req_valid  out  1  bus request valid.
- req_ready  in  1  bus request accepted.
- req_wr  out  1  1 = write.
- req_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}.
- req_wstrb  out  4  byte strobes; 0 for reads.
- req_wdata  out  32  write data.
- resp_valid  in  1  read data returned (one beat, no backpressure).
- resp_rdata  in  32  read data.
- wb_valid  out  1  one-cycle completion pulse.
- wb_we  out  1  register write required (loads only).
- wb_data  out  32  extended/merged load result.

Behaviour:
- Reset: state IDLE; req_valid=0, req_wr=0, req_addr=0, req_wstrb=0, req_wdata=0, wb_valid=0, wb_we=0, wb_data=0, ex_ready=1.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - ex_ready=1. Accept when ex_valid & ~flush. Latch addr, wdata, wstrb, ext_type, rt_old, offset = addr[1:0].
  - Accepted with ex_addr_err=1, or neither load nor store: no bus activity; wb_valid=1, wb_we=0 next cycle; stay IDLE.
  - Otherwise go to REQ. req_valid rises the cycle after accept.
- REQ:
  - Hold req_valid and all req_* stable until req_ready.
  - Handshake on a store: posted write. Next cycle wb_valid=1, wb_we=0; go to IDLE.
  - Handshake on a load: go to WAIT.
  - flush before the handshake: drop req_valid next cycle; go to IDLE; no wb pulse.
  - flush in the same cycle as req_ready: the request counts as issued. Store completes with no wb pulse. Load goes to DRAIN.
- WAIT:
  - On resp_valid, compute the result from resp_rdata and offset o. Next cycle wb_valid=1, wb_we=1, wb_data=result; go to IDLE.
  - Result rules:
    - lb/lbu: byte at lane o, sign-/zero-extended.
    - lh/lhu: halfword at lane o[1], sign-/zero-extended.
    - lw: full word.
    - lwl: (rdata << 8*(3-o)) | (rt_old & (32'hFFFFFFFF >> 8*(o+1))); for o=3 the mask is 0.
    - lwr: (rdata >> 8*o) | (rt_old & ~(32'hFFFFFFFF >> 8*o)).
  - flush (including a flush coincident with resp_valid): go to DRAIN, or IDLE if resp_valid arrives the same cycle; no wb pulse.
- DRAIN: wait for resp_valid, discard it, go to IDLE. ex_ready=0.
- ex_ready=0 in REQ, WAIT and DRAIN.
- Back-to-back ops: a new op is accepted in the IDLE cycle in which wb_valid is high.
- Minimum load latency: accept T, req T+1, resp R ≥ T+2, wb_valid R+1.
- wb_data holds its value between pulses. wb_valid is exactly one cycle.
- resetn asserted mid-transaction: all state returns to reset values immediately. The bus fabric is reset by the same resetn.

Decomposition:
- Shared package:
  - state enum (IDLE/REQ/WAIT/DRAIN).
  - ext_type bit-index constants (EXT_LB=8 ... EXT_SWR=0) so the decode unit and this block index identically.
- Sub-module load_data_align: purely combinational extension/merge (rdata, rt_old, offset, ext_type -> result).

Test Plan:
- lb at addr 0x1003, resp_rdata 0x80FF_1234 -> wb_we=1, wb_data 0xFFFF_FF80. Same address with lbu -> 0x0000_0080.
- lwl at addr 0x2001, rt_old 0xAABB_CCDD, rdata 0x1122_3344 -> wb_data 0x3344_CCDD. lwr at 0x2001 -> 0xAA11_2233.
- sw to 0x3000, req_ready held low 3 cycles -> req_* stable for 4 cycles, ex_ready=0, then one wb_valid with wb_we=0.
- Load issued, flush in WAIT, resp_valid 2 cycles later -> no wb_valid, ex_ready=0 until resp, then 1.
- ex_addr_err=1 on lw at 0x4002 -> req_valid never rises, wb_valid=1 with wb_we=0 next cycle.
- resetn pulled low while in WAIT -> all outputs at reset values within the same cycle, state IDLE.
